// File: rtl/spi_slave_if_if.sv
// spi_slave_if_if: SPI pin bundle between a master and the spi_slave_if endpoint.
interface spi_slave_if_if;
    logic sclk_in;
    logic ss_n_in;
    logic mosi_in;
    logic miso_out;
    logic miso_oe;
    modport slave (input sclk_in, ss_n_in, mosi_in, output miso_out, miso_oe);
    modport master (output sclk_in, ss_n_in, mosi_in, input miso_out, miso_oe);
endinterface

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI peripheral endpoint oversampling sclk/ss_n/mosi in the wb_clk_in domain.
module spi_slave_if #(
    parameter int DW = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic          wb_clk_in,
    input  logic          wb_rst_in,
    spi_slave_if_if.slave spi,
    input  logic          rx_negedge,
    input  logic          tx_negedge,
    input  logic          lsb,
    input  logic [4:0]    char_len,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_load,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ack,
    input  logic          clr_flags,
    output logic          overrun,
    output logic          underrun,
    output logic          busy
);
    localparam int AW = $clog2(DW);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sclk_s, ss_s, mosi_s;
    logic [SYNC_STAGES:0] warm;
    logic sclk_d, ss_d, armed;
    logic p_rx, p_tx, p_start, p_stop, bit_q;
    logic [DW-1:0] tx_sr, rx_sr, hold, rx_next, load_val;
    logic [5:0] cnt, len;
    logic [AW-1:0] top;
    logic adv_ok, miso_r, oe_r;
    logic sclk_l, ss_l, mosi_l, sclk_rise, sclk_fall;
    logic done, complete, reload, ovr_set, und_set, load_ok;

    assign sclk_l = sclk_s[SYNC_STAGES-1];
    assign ss_l = ss_s[SYNC_STAGES-1];
    assign mosi_l = mosi_s[SYNC_STAGES-1];
    assign sclk_rise = sclk_l & ~sclk_d;
    assign sclk_fall = ~sclk_l & sclk_d;
    assign len = (char_len == 5'd0) ? 6'd32 : {1'b0, char_len};
    assign top = AW'(len - 6'd1);
    assign rx_next = lsb ? ((rx_sr >> 1) | (DW'(bit_q) << top)) : {rx_sr[DW-2:0], bit_q};
    assign done = p_rx && (cnt + 6'd1 == len);
    assign complete = (state == ACTIVE) && !p_stop && done;
    assign reload = p_start | complete;
    assign load_val = tx_ready ? '0 : hold;
    assign ovr_set = complete & rx_valid & ~rx_ack;
    assign und_set = reload & tx_ready;
    assign load_ok = tx_load & tx_ready;
    assign spi.miso_out = miso_r;
    assign spi.miso_oe = oe_r;

    always_ff @(posedge wb_clk_in) begin
        if (wb_rst_in) begin
            sclk_s <= '0;
            ss_s <= '1;
            mosi_s <= '0;
            sclk_d <= 1'b0;
            ss_d <= 1'b1;
            warm <= '0;
            armed <= 1'b0;
            p_rx <= 1'b0;
            p_tx <= 1'b0;
            p_start <= 1'b0;
            p_stop <= 1'b0;
            bit_q <= 1'b0;
            state <= IDLE;
            tx_sr <= '0;
            rx_sr <= '0;
            cnt <= '0;
            adv_ok <= 1'b0;
            hold <= '0;
            tx_ready <= 1'b1;
            rx_data <= '0;
            rx_valid <= 1'b0;
            overrun <= 1'b0;
            underrun <= 1'b0;
            miso_r <= 1'b0;
            oe_r <= 1'b0;
            busy <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[SYNC_STAGES-2:0], spi.sclk_in};
            ss_s <= {ss_s[SYNC_STAGES-2:0], spi.ss_n_in};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi.mosi_in};
            sclk_d <= sclk_l;
            ss_d <= ss_l;
            // a frame may only start once select has been seen high after the synchronisers flushed
            warm <= {warm[SYNC_STAGES-1:0], 1'b1};
            armed <= armed | (warm[SYNC_STAGES] & ss_l & ss_d);
            p_rx <= rx_negedge ? sclk_fall : sclk_rise;
            p_tx <= tx_negedge ? sclk_fall : sclk_rise;
            p_start <= armed & ss_d & ~ss_l;
            p_stop <= ~ss_d & ss_l;
            bit_q <= mosi_l;
            if (p_start) begin
                state <= ACTIVE;
                tx_sr <= load_val;
                rx_sr <= '0;
                cnt <= '0;
                adv_ok <= 1'b0;
            end else if (state == ACTIVE) begin
                if (p_stop) begin
                    state <= IDLE;
                end else if (p_rx) begin
                    adv_ok <= ~done;
                    cnt <= done ? 6'd0 : cnt + 6'd1;
                    rx_sr <= done ? '0 : rx_next;
                    if (done) tx_sr <= load_val;
                end else if (p_tx && adv_ok) begin
                    tx_sr <= lsb ? (tx_sr >> 1) : (tx_sr << 1);
                    adv_ok <= 1'b0;
                end
            end
            if (complete && !ovr_set) begin
                rx_data <= rx_next;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
            if (load_ok) hold <= tx_data;
            tx_ready <= load_ok ? 1'b0 : (reload ? 1'b1 : tx_ready);
            overrun <= ovr_set | (overrun & ~clr_flags);
            underrun <= und_set | (underrun & ~clr_flags);
            miso_r <= (state == ACTIVE) & (lsb ? tx_sr[0] : tx_sr[top]);
            oe_r <= state == ACTIVE;
            busy <= state == ACTIVE;
        end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed SPI master driving spi_slave_if with rx/miso scoreboards.
module tb_spi_slave_if;
    localparam int HALF = 8;
    logic clk = 1'b0;
    logic rst;
    logic rx_negedge, tx_negedge, lsb;
    logic [4:0] char_len;
    logic [31:0] tx_data;
    logic tx_load, rx_ack, clr_flags;
    logic tx_ready, rx_valid, overrun, underrun, busy;
    logic [31:0] rx_data;
    logic [31:0] mi;
    logic [31:0] rx_q[$];
    logic [31:0] miso_q[$];
    int vectors = 0;
    int errors = 0;

    spi_slave_if_if bus();

    spi_slave_if #(.DW(32), .SYNC_STAGES(2)) dut (
        .wb_clk_in(clk),
        .wb_rst_in(rst),
        .spi(bus),
        .rx_negedge(rx_negedge),
        .tx_negedge(tx_negedge),
        .lsb(lsb),
        .char_len(char_len),
        .tx_data(tx_data),
        .tx_load(tx_load),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ack(rx_ack),
        .clr_flags(clr_flags),
        .overrun(overrun),
        .underrun(underrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_mode(input logic rn, input logic tn, input logic l, input logic [4:0] cl);
        rx_negedge = rn;
        tx_negedge = tn;
        lsb = l;
        char_len = cl;
    endtask

    task automatic load(input logic [31:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
    endtask

    task automatic ss_low();
        bus.ss_n_in = 1'b0;
        tick(HALF);
    endtask

    task automatic ss_high();
        bus.ss_n_in = 1'b1;
        tick(HALF);
    endtask

    task automatic xfer(input int n, input logic [31:0] mo, output logic [31:0] m);
        m = '0;
        for (int i = 0; i < n; i++) begin
            int b;
            b = lsb ? i : n - 1 - i;
            if (!rx_negedge) begin
                bus.mosi_in = mo[b];
                tick(HALF);
                m[b] = bus.miso_out;
                bus.sclk_in = 1'b1;
                tick(HALF);
                bus.sclk_in = 1'b0;
            end else begin
                bus.sclk_in = 1'b1;
                bus.mosi_in = mo[b];
                tick(HALF);
                m[b] = bus.miso_out;
                bus.sclk_in = 1'b0;
                tick(HALF);
            end
        end
        tick(HALF);
    endtask

    task automatic wait_rx();
        int n;
        n = 0;
        @(negedge clk);
        while (rx_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rx_valid_rise", {31'd0, rx_valid}, 32'd1);
    endtask

    task automatic pop_rx();
        logic [31:0] e;
        e = rx_q.pop_front();
        wait_rx();
        check("rx_data", rx_data, e);
    endtask

    task automatic pop_miso(input logic [31:0] got);
        logic [31:0] e;
        e = miso_q.pop_front();
        check("miso_word", got, e);
    endtask

    initial begin
        rst = 1'b1;
        bus.sclk_in = 1'b0;
        bus.ss_n_in = 1'b1;
        bus.mosi_in = 1'b0;
        set_mode(1'b0, 1'b1, 1'b0, 5'd8);
        tx_data = '0;
        tx_load = 1'b0;
        rx_ack = 1'b0;
        clr_flags = 1'b0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outs", {25'd0, bus.miso_out, bus.miso_oe, tx_ready, rx_valid, overrun, underrun, busy}, 32'h10);
        check("reset_rx_data", rx_data, 32'h0);
        tick(HALF);

        // mode 0, MSB first, 8 bits
        load(32'h3C);
        @(negedge clk);
        check("m0_tx_ready_full", {31'd0, tx_ready}, 32'd0);
        rx_q.push_back(32'hA5);
        miso_q.push_back(32'h3C);
        ss_low();
        @(negedge clk);
        check("m0_start", {29'd0, tx_ready, busy, bus.miso_oe}, 32'h7);
        xfer(8, 32'hA5, mi);
        pop_miso(mi);
        pop_rx();
        pulse_ack();
        @(negedge clk);
        check("m0_ack", {31'd0, rx_valid}, 32'd0);
        ss_high();
        check("m0_single_valid", {31'd0, rx_valid}, 32'd0);
        check("m0_idle", {30'd0, busy, bus.miso_oe}, 32'd0);
        pulse_clr();

        // mode 1, LSB first, 16 bits, next word queued so no underrun
        set_mode(1'b1, 1'b0, 1'b1, 5'd16);
        load(32'h1234);
        rx_q.push_back(32'hBEEF);
        miso_q.push_back(32'h1234);
        ss_low();
        @(negedge clk);
        check("m1_tx_ready", {31'd0, tx_ready}, 32'd1);
        load(32'hFFFF);
        xfer(16, 32'hBEEF, mi);
        pop_miso(mi);
        pop_rx();
        check("m1_no_underrun", {31'd0, underrun}, 32'd0);
        pulse_ack();
        ss_high();

        // back-to-back words without rx_ack
        set_mode(1'b0, 1'b1, 1'b0, 5'd8);
        rx_q.push_back(32'h11);
        ss_low();
        xfer(8, 32'h11, mi);
        xfer(8, 32'h22, mi);
        pop_rx();
        check("b2b_overrun", {31'd0, overrun}, 32'd1);
        pulse_clr();
        @(negedge clk);
        check("b2b_clr", {30'd0, overrun, underrun}, 32'd0);
        pulse_ack();
        @(negedge clk);
        check("b2b_ack", {31'd0, rx_valid}, 32'd0);
        ss_high();

        // 32-bit word with empty holding buffer
        set_mode(1'b0, 1'b1, 1'b0, 5'd0);
        rx_q.push_back(32'hDEADBEEF);
        miso_q.push_back(32'h0);
        ss_low();
        @(negedge clk);
        check("w32_underrun", {31'd0, underrun}, 32'd1);
        xfer(32, 32'hDEADBEEF, mi);
        pop_miso(mi);
        pop_rx();
        pulse_ack();
        ss_high();
        pulse_clr();

        // aborted partial frame, then a full one
        set_mode(1'b0, 1'b1, 1'b0, 5'd8);
        ss_low();
        xfer(5, 32'h1F, mi);
        ss_high();
        tick(HALF);
        check("abort_no_valid", {31'd0, rx_valid}, 32'd0);
        rx_q.push_back(32'h5A);
        ss_low();
        xfer(8, 32'h5A, mi);
        pop_rx();
        pulse_ack();
        ss_high();

        // reset mid-frame
        load(32'h77);
        ss_low();
        load(32'h99);
        xfer(3, 32'h5, mi);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_outs", {25'd0, bus.miso_out, bus.miso_oe, tx_ready, rx_valid, overrun, underrun, busy}, 32'h10);
        check("midrst_rx_data", rx_data, 32'h0);
        tick(2 * HALF);
        check("midrst_stay_idle", {30'd0, busy, bus.miso_oe}, 32'd0);
        ss_high();
        rx_q.push_back(32'hC3);
        ss_low();
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd1);
        xfer(8, 32'hC3, mi);
        pop_rx();
        pulse_ack();
        ss_high();
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
